fcr_multi: RTL and testbench

FCR_MULTI -- requirements
Module: fcr_multi

---
 rtl/fcr_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_fcr_multi.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fcr_multi.sv
// fcr_multi: command-driven control block for N_CH tap channels.
// It reads one 32-bit command word from a show-ahead command source and
// applies it to a per-channel gate-time/threshold/mode register or to the
// status block. It then writes one 32-bit response word to the response sink.
// Command word layout: {target[31:24], opcode[23:16], payload[15:0]}.
// GET_CMDCNT reports the count of commands executed before the current one.
module fcr_multi #(
    parameter int N_CH   = 4,
    parameter int GT_W   = 16,
    parameter int THR_W  = 16,
    parameter int MODE_W = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [31:0]                            cmd_data,
    input  logic                                   cmd_waitreq,
    output logic                                   cmd_rdreq,
    output logic [31:0]                            rsp_data,
    output logic                                   rsp_wrreq,
    input  logic                                   rsp_waitreq,
    output logic [N_CH*(MODE_W+THR_W+GT_W)-1:0]    tap_ctl,
    output logic                                   err_flag
);

    localparam int SL = MODE_W + THR_W + GT_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q;
    logic [31:0]         cmd_q;
    logic [31:0]         rsp_data_q;
    logic [15:0]         cmd_cnt_q;
    logic [15:0]         err_cnt_q;
    logic                err_flag_q;
    logic [GT_W-1:0]     gt_q   [N_CH];
    logic [THR_W-1:0]    thr_q  [N_CH];
    logic [MODE_W-1:0]   mode_q [N_CH];

    logic [7:0]          tgt_s;
    logic [7:0]          op_s;
    logic [15:0]         pl_s;
    logic                ch_hit_s;
    logic [GT_W-1:0]     cur_gt_s;
    logic [THR_W-1:0]    cur_thr_s;
    logic [MODE_W-1:0]   cur_mode_s;
    logic [31:0]         rsp_d;
    logic                err_s;
    logic [7:0]          code_s;
    logic                set_gt_s;
    logic                set_thr_s;
    logic                set_mode_s;
    logic                clr_s;
    logic [N_CH*SL-1:0]  tap_s;

    assign tgt_s = cmd_q[31:24];
    assign op_s  = cmd_q[23:16];
    assign pl_s  = cmd_q[15:0];

    // Strobes come from the state register; reset masks them in its own cycle.
    assign cmd_rdreq = (state_q == S_RD) && !rst;
    assign rsp_wrreq = (state_q == S_RESP) && !rsp_waitreq && !rst;
    assign rsp_data  = rsp_data_q;
    assign err_flag  = err_flag_q;
    assign tap_ctl   = tap_s;

    // Select the addressed channel's current register values.
    always_comb begin
        ch_hit_s   = 1'b0;
        cur_gt_s   = '0;
        cur_thr_s  = '0;
        cur_mode_s = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_hit_s   = ch_hit_s | (tgt_s == (8'h10 + 8'(c)));
            cur_gt_s   = (tgt_s == (8'h10 + 8'(c))) ? gt_q[c]   : cur_gt_s;
            cur_thr_s  = (tgt_s == (8'h10 + 8'(c))) ? thr_q[c]  : cur_thr_s;
            cur_mode_s = (tgt_s == (8'h10 + 8'(c))) ? mode_q[c] : cur_mode_s;
        end
    end

    // Decode the latched command into register actions and a response word.
    always_comb begin
        rsp_d      = 32'h0000_0000;
        err_s      = 1'b0;
        code_s     = 8'h00;
        set_gt_s   = 1'b0;
        set_thr_s  = 1'b0;
        set_mode_s = 1'b0;
        clr_s      = 1'b0;
        if (tgt_s == 8'h00) begin
            case (op_s)
                8'h90:   rsp_d = {8'h00, 8'h90, cmd_cnt_q};
                8'h91:   rsp_d = {8'h00, 8'h91, err_cnt_q};
                8'h92: begin
                    clr_s = 1'b1;
                    rsp_d = {tgt_s, op_s, 16'h0000};
                end
                default: begin
                    err_s  = 1'b1;
                    code_s = 8'h01;
                end
            endcase
        end else if (ch_hit_s) begin
            case (op_s)
                8'h01: begin
                    set_gt_s = 1'b1;
                    rsp_d    = {tgt_s, op_s, 16'(pl_s[GT_W-1:0])};
                end
                8'h02: begin
                    set_thr_s = 1'b1;
                    rsp_d     = {tgt_s, op_s, 16'(pl_s[THR_W-1:0])};
                end
                8'h03: begin
                    set_mode_s = 1'b1;
                    rsp_d      = {tgt_s, op_s, 16'(pl_s[MODE_W-1:0])};
                end
                8'h81:   rsp_d = {tgt_s, op_s, 16'(cur_gt_s)};
                8'h82:   rsp_d = {tgt_s, op_s, 16'(cur_thr_s)};
                8'h83:   rsp_d = {tgt_s, op_s, 16'(cur_mode_s)};
                default: begin
                    err_s  = 1'b1;
                    code_s = 8'h01;
                end
            endcase
        end else if (tgt_s[7:4] == 4'h1) begin
            err_s  = 1'b1;
            code_s = 8'h02;
        end else begin
            err_s  = 1'b1;
            code_s = 8'h03;
        end
        if (err_s) begin
            rsp_d = {tgt_s, 8'hFF, op_s, code_s};
        end else begin
            rsp_d = rsp_d;
        end
    end

    // Pack channel registers onto tap_ctl, {mode, thr, gt} per slice.
    always_comb begin
        tap_s = '0;
        for (int c = 0; c < N_CH; c++) begin
            tap_s[c*SL +: SL] = {mode_q[c], thr_q[c], gt_q[c]};
        end
    end

    // Command FSM with command latch, execution datapath and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= 32'h0000_0000;
            rsp_data_q <= 32'h0000_0000;
            cmd_cnt_q  <= 16'h0000;
            err_cnt_q  <= 16'h0000;
            err_flag_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                gt_q[c]   <= '0;
                thr_q[c]  <= '0;
                mode_q[c] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!cmd_waitreq) begin
                        state_q <= S_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    cmd_q   <= cmd_data;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_data_q <= rsp_d;
                    cmd_cnt_q  <= cmd_cnt_q + 16'd1;
                    if (clr_s) begin
                        err_cnt_q  <= 16'h0000;
                        err_flag_q <= 1'b0;
                    end else if (err_s) begin
                        err_flag_q <= 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end else begin
                            err_cnt_q <= err_cnt_q;
                        end
                    end else begin
                        err_flag_q <= err_flag_q;
                    end
                    for (int c = 0; c < N_CH; c++) begin
                        if (tgt_s == (8'h10 + 8'(c))) begin
                            if (set_gt_s)   gt_q[c]   <= pl_s[GT_W-1:0];
                            if (set_thr_s)  thr_q[c]  <= pl_s[THR_W-1:0];
                            if (set_mode_s) mode_q[c] <= pl_s[MODE_W-1:0];
                        end
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (!rsp_waitreq) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcr_multi.sv
// Scoreboard bench for fcr_multi (N_CH=4, GT_W=8, THR_W=16, MODE_W=2).
// Inputs change 1 time unit after a rising edge; the monitor samples on falling edges.
module tb_fcr_multi;

    localparam int N_CH = 4;
    localparam int GT_W = 8;
    localparam int THR_W = 16;
    localparam int MODE_W = 2;
    localparam int SL = MODE_W + THR_W + GT_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          cmd_data;
    logic                 cmd_waitreq;
    logic                 cmd_rdreq;
    logic [31:0]          rsp_data;
    logic                 rsp_wrreq;
    logic                 rsp_waitreq;
    logic [N_CH*SL-1:0]   tap_ctl;
    logic                 err_flag;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] exp_q[$];

    logic [GT_W-1:0]   m_gt   [N_CH];
    logic [THR_W-1:0]  m_thr  [N_CH];
    logic [MODE_W-1:0] m_mode [N_CH];

    fcr_multi #(.N_CH(N_CH), .GT_W(GT_W), .THR_W(THR_W), .MODE_W(MODE_W)) dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_waitreq(cmd_waitreq),
        .cmd_rdreq(cmd_rdreq), .rsp_data(rsp_data), .rsp_wrreq(rsp_wrreq),
        .rsp_waitreq(rsp_waitreq), .tap_ctl(tap_ctl), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts strobes and scores each written response against the queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (cmd_rdreq === 1'b1) rd_cnt++;
            if (rsp_wrreq === 1'b1) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {96'd0, rsp_data}, 128'd0 - 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", {96'd0, rsp_data}, {96'd0, e});
                end
            end
        end
    end

    task automatic check_taps(input string nm);
        logic [N_CH*SL-1:0] exp_tap;
        exp_tap = '0;
        for (int c = 0; c < N_CH; c++) exp_tap[c*SL +: SL] = {m_mode[c], m_thr[c], m_gt[c]};
        check(nm, 128'(tap_ctl), 128'(exp_tap));
    endtask

    // Start a command: one cycle of cmd_waitreq=0, leaving the FSM in RD.
    task automatic start_cmd(input logic [31:0] word);
        step();
        cmd_data = word;
        cmd_waitreq = 1'b0;
        step();
        cmd_waitreq = 1'b1;
    endtask

    task automatic issue(input logic [31:0] word, input logic [31:0] exp_rsp);
        int r0, w0, n;
        r0 = rd_cnt;
        w0 = wr_cnt;
        exp_q.push_back(exp_rsp);
        start_cmd(word);
        n = 0;
        while (wr_cnt == w0 && n < 20) begin
            step();
            n++;
        end
        check("rsp_seen", 128'(wr_cnt), 128'(w0 + 1));
        check("one_rdreq", 128'(rd_cnt), 128'(r0 + 1));
    endtask

    initial begin
        int r0, w0;
        for (int c = 0; c < N_CH; c++) begin
            m_gt[c] = '0; m_thr[c] = '0; m_mode[c] = '0;
        end
        rst = 1'b1;
        cmd_data = 32'h0;
        cmd_waitreq = 1'b1;
        rsp_waitreq = 1'b0;
        repeat (3) step();
        check("rst_tap", 128'(tap_ctl), 128'd0);
        check("rst_rsp", 128'(rsp_data), 128'd0);
        check("rst_err", 128'(err_flag), 128'd0);
        check("rst_strobes", 128'({cmd_rdreq, rsp_wrreq}), 128'd0);
        rst = 1'b0;
        step();

        issue(32'h10010001, 32'h10010001); m_gt[0] = 8'h01;
        check_taps("tap_gt0_1");
        issue(32'h10AA0001, 32'h10FFAA01);
        check("err_flag_set", 128'(err_flag), 128'd1);
        check_taps("tap_unchanged_err");
        issue(32'h00920000, 32'h00920000);
        check("err_flag_clr", 128'(err_flag), 128'd0);
        issue(32'h1302AAAA, 32'h1302AAAA); m_thr[3] = 16'hAAAA;
        issue(32'h13820000, 32'h1382AAAA);
        issue(32'h15010001, 32'h15FF0102);
        check("err_flag_ch", 128'(err_flag), 128'd1);
        issue(32'h10011234, 32'h10010034); m_gt[0] = 8'h34;
        check_taps("tap_gt_trunc");
        issue(32'h00910000, 32'h00910001);
        issue(32'h00900000, 32'h00900008);
        issue(32'h20830000, 32'h20FF8303);
        issue(32'h12030007, 32'h12030003); m_mode[2] = 2'd3;
        issue(32'h12830000, 32'h12830003);
        issue(32'h11810000, 32'h11810000);
        issue(32'h00770000, 32'h00FF7701);
        check_taps("tap_mid");

        // Response backpressure for 10 cycles with a command waiting.
        rsp_waitreq = 1'b1;
        r0 = rd_cnt;
        w0 = wr_cnt;
        exp_q.push_back(32'h11010055);
        start_cmd(32'h11015555); m_gt[1] = 8'h55;
        repeat (3) step();
        cmd_waitreq = 1'b0;
        repeat (10) step();
        check("hold_no_wr", 128'(wr_cnt), 128'(w0));
        check("hold_no_rd", 128'(rd_cnt), 128'(r0 + 1));
        check("hold_rsp_stable", 128'(rsp_data), 128'h11010055);
        rsp_waitreq = 1'b0;
        cmd_waitreq = 1'b1;
        repeat (3) step();
        check("release_one_wr", 128'(wr_cnt), 128'(w0 + 1));
        check("release_no_rd", 128'(rd_cnt), 128'(r0 + 1));

        // Reset in EXEC of SET_THR aborts the command.
        w0 = wr_cnt;
        start_cmd(32'h10020BCD);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            m_gt[c] = '0; m_thr[c] = '0; m_mode[c] = '0;
        end
        repeat (6) step();
        check("abort_no_wr", 128'(wr_cnt), 128'(w0));
        check_taps("abort_tap_zero");
        check("abort_err_flag", 128'(err_flag), 128'd0);
        issue(32'h00900000, 32'h00900000);
        issue(32'h10820000, 32'h10820000);
        issue(32'h10020BCD, 32'h10020BCD); m_thr[0] = 16'h0BCD;
        check_taps("tap_after_abort");

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
